// File: rtl/secjmp_monitor.sv
// secjmp_monitor: registered stage behind the jump-security filter.
// Forwards the filtered word stream through a 2-entry valid/ready buffer,
// counts words the filter suppressed, remembers the last offender, and
// raises a sticky alarm when suppressions within one window hit THRESH.
module secjmp_monitor #(
    parameter int WIDTH        = 64,
    parameter int CNT_W        = 16,
    parameter int THRESH       = 4,
    parameter int WINDOW       = 256,
    parameter bit DROP_BLOCKED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_raw,
    input  logic [WIDTH-1:0] in_filt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr,
    output logic             alarm,
    output logic [CNT_W-1:0] blk_count,
    output logic [WIDTH-1:0] last_blk
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    // One spare bit so win_hits + blocked never wraps before the compare.
    localparam int HW = $clog2(THRESH + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATCH = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [1:0]      occ;
    logic [WIDTH-1:0] head, tail;
    logic [WW-1:0]   win_cnt;
    logic [HW-1:0]   win_hits, hits_now;

    logic accept, blocked, push, pop, wrap, thr_hit;

    // Handshake and classification of the incoming word.
    always_comb begin
        in_ready  = (occ != 2'd2) && (state != ALARM);
        accept    = in_valid && in_ready;
        blocked   = accept && (|in_raw) && !(|in_filt);
        push      = accept && !(blocked && DROP_BLOCKED);
        out_valid = (occ != 2'd0);
        pop       = out_valid && out_ready;
        wrap      = (win_cnt == WW'(WINDOW - 1));
        hits_now  = win_hits + HW'(blocked);
        thr_hit   = (hits_now >= HW'(THRESH));
    end

    assign out_data = head;
    assign alarm    = (state == ALARM);

    // Buffer: head is the visible entry, tail the second slot. head keeps
    // its last value when the buffer empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= in_filt;
                    else             tail <= in_filt;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) head <= tail;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= in_filt;
                    end else begin
                        head <= tail;
                        tail <= in_filt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; the threshold test includes this cycle's blocked
    // word, so a hit on the wrap cycle still counts toward the old window.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (thr_hit)      state_n = ALARM;
                else if (blocked) state_n = WATCH;
            end
            WATCH: begin
                if (thr_hit)      state_n = ALARM;
                else if (wrap)    state_n = IDLE;
            end
            ALARM:   state_n = ALARM;
            default: state_n = IDLE;
        endcase
    end

    // State register; clr overrides everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (clr) state <= IDLE;
        else          state <= state_n;
    end

    // Window, hit and total counters; frozen while alarmed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt   <= '0;
            win_hits  <= '0;
            blk_count <= '0;
        end else if (clr) begin
            win_cnt   <= '0;
            win_hits  <= '0;
            blk_count <= '0;
        end else if (state != ALARM) begin
            win_cnt  <= wrap ? '0 : win_cnt + WW'(1);
            win_hits <= wrap ? '0 : hits_now;
            if (blocked && (blk_count != {CNT_W{1'b1}}))
                blk_count <= blk_count + CNT_W'(1);
        end
    end

    // Last offender: raw word of the most recent blocked accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_blk <= '0;
        else if (blocked) last_blk <= in_raw;
    end

endmodule

// File: tb/tb_secjmp_monitor.sv
// Bench for secjmp_monitor: scoreboard on the forwarded stream plus
// directed checks of counters, window, alarm, clr and reset.
module tb_secjmp_monitor;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, in_valid_fw, out_ready;
    logic [63:0] in_raw, in_filt;
    logic        in_ready, out_valid, alarm;
    logic [63:0] out_data, last_blk;
    logic [15:0] blk_count;
    logic        fw_in_ready, fw_out_valid, fw_alarm;
    logic [63:0] fw_out_data, fw_last_blk;
    logic [15:0] fw_blk_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [63:0] sb[$];
    logic [63:0] exp_w;

    localparam logic [63:0] BLK  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] BLK2 = 64'h0000_0000_0800_0100;
    localparam logic [63:0] PASS = 64'h0000_0000_0800_0010;

    secjmp_monitor dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_raw(in_raw), .in_filt(in_filt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .clr(clr),
        .alarm(alarm), .blk_count(blk_count), .last_blk(last_blk)
    );

    secjmp_monitor #(.DROP_BLOCKED(1'b0)) dut_fw (
        .clk(clk), .rst(rst), .in_valid(in_valid_fw), .in_ready(fw_in_ready),
        .in_raw(in_raw), .in_filt(in_filt), .out_valid(fw_out_valid),
        .out_ready(out_ready), .out_data(fw_out_data), .clr(clr),
        .alarm(fw_alarm), .blk_count(fw_blk_count), .last_blk(fw_last_blk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Window position expected at the start of each cycle.
    always @(posedge clk or posedge rst) begin
        if (rst)             cyc <= 0;
        else if (clr)        cyc <= 0;
        else                 cyc <= (cyc == 255) ? 0 : cyc + 1;
    end

    // Scoreboard compare on each output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_w = sb.pop_front();
                chk("out_data", out_data, exp_w);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_valid_fw = 1'b0;
        out_ready = 1'b1; in_raw = '0; in_filt = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Present one word, wait (bounded) for acceptance; scoreboard it unless dropped.
    task automatic send(input logic [63:0] raw, input logic [63:0] filt);
        int n = 0;
        in_valid = 1'b1; in_raw = raw; in_filt = filt;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        else if (!(raw != 0 && filt == 0)) sb.push_back(filt);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        int n = 0;
        while (cyc != k && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (cyc != k) chk("wait_timeout", 64'(cyc), 64'(k));
    endtask

    initial begin
        int n;
        do_reset();
        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_alarm",     64'(alarm), 64'd0);
        chk("rst_blk_count", 64'(blk_count), 64'd0);
        chk("rst_last_blk",  last_blk, 64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd1);

        // pass-through, one-cycle latency
        send(PASS, PASS);
        chk("pt_valid", 64'(out_valid), 64'd1);
        chk("pt_data",  out_data, PASS);
        @(posedge clk); #1;
        chk("pt_drained", 64'(out_valid), 64'd0);
        chk("pt_blk",     64'(blk_count), 64'd0);
        chk("pt_alarm",   64'(alarm), 64'd0);

        // blocked word, dropped
        send(BLK, 64'd0);
        chk("drop_valid", 64'(out_valid), 64'd0);
        chk("drop_blk",   64'(blk_count), 64'd1);
        chk("drop_last",  last_blk, BLK);
        chk("drop_state", 64'(dut.state), 64'd1);

        // blocked word, forwarded as zero
        in_valid_fw = 1'b1; in_raw = BLK; in_filt = 64'd0;
        @(posedge clk); #1;
        in_valid_fw = 1'b0;
        chk("fw_valid", 64'(fw_out_valid), 64'd1);
        chk("fw_data",  fw_out_data, 64'd0);
        chk("fw_blk",   64'(fw_blk_count), 64'd1);

        // backpressure: third word waits for room
        do_reset();
        out_ready = 1'b0;
        send(64'h11, 64'h11);
        send(64'h22, 64'h22);
        in_valid = 1'b1; in_raw = 64'h33; in_filt = 64'h33;
        @(negedge clk);
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        chk("bp_head",       out_data, 64'h11);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin n++; @(negedge clk); end
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        if (in_ready) sb.push_back(64'h33);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        chk("bp_out_idle", 64'(out_valid), 64'd0);

        // window expiry, then 4th hit on the wrap cycle
        do_reset();
        wait_cyc(10); send(BLK, 64'd0);
        wait_cyc(20); send(BLK, 64'd0);
        wait_cyc(30); send(BLK, 64'd0);
        wait_cyc(40);
        chk("win_watch", 64'(dut.state), 64'd1);
        wait_cyc(0);
        chk("win_idle",  64'(dut.state), 64'd0);
        wait_cyc(44); send(BLK, 64'd0);
        chk("win_no_alarm", 64'(alarm), 64'd0);
        chk("win_blk4",     64'(blk_count), 64'd4);
        wait_cyc(50); send(BLK, 64'd0);
        wait_cyc(60); send(BLK, 64'd0);
        wait_cyc(254);
        chk("wrap_pre_alarm", 64'(alarm), 64'd0);
        wait_cyc(255); send(BLK2, 64'd0);
        chk("wrap_alarm",    64'(alarm), 64'd1);
        chk("wrap_blk7",     64'(blk_count), 64'd7);
        chk("wrap_in_ready", 64'(in_ready), 64'd0);
        do_clr();
        chk("clr_alarm", 64'(alarm), 64'd0);
        chk("clr_blk",   64'(blk_count), 64'd0);
        chk("clr_ready", 64'(in_ready), 64'd1);

        // clr coincident with a blocked word
        clr = 1'b1;
        send(BLK, 64'd0);
        clr = 1'b0;
        chk("clrco_blk",   64'(blk_count), 64'd0);
        chk("clrco_state", 64'(dut.state), 64'd0);

        // alarm with a buffered word that still drains
        out_ready = 1'b0;
        send(BLK, 64'd0);
        send(BLK, 64'd0);
        send(BLK, 64'd0);
        send(64'hA5, 64'hA5);
        send(BLK2, 64'd0);
        chk("al_alarm", 64'(alarm), 64'd1);
        chk("al_ready", 64'(in_ready), 64'd0);
        chk("al_valid", 64'(out_valid), 64'd1);
        chk("al_blk",   64'(blk_count), 64'd4);
        chk("al_last",  last_blk, BLK2);
        out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("al_drained", 64'(out_valid), 64'd0);
        chk("al_sticky",  64'(alarm), 64'd1);
        chk("al_halt",    64'(in_ready), 64'd0);
        do_clr();
        chk("al_clr_alarm", 64'(alarm), 64'd0);
        chk("al_clr_blk",   64'(blk_count), 64'd0);
        chk("al_clr_ready", 64'(in_ready), 64'd1);

        // async reset mid-stream
        out_ready = 1'b0;
        send(64'h77, 64'h77);
        send(64'h88, 64'h88);
        chk("ar_full", 64'(out_valid), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_data",  out_data, 64'd0);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ar_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
